mac_qdot: RTL and testbench
===========================

// Module: mac_qdot
// PURPOSE
//  Parametrised multi-lane quantized dot-product MAC, the successor to the single-lane int8/fp16 MAC.
//  Each of LANES lanes accumulates cfg_len beats of int8 (or packed int4) products into a wide accumulator.
//  At the end of a dot product it adds a per-lane bias, requantizes (rounding right shift), saturates to int8,
//  and emits the result. Sits between operand fetch and the activation/writeback stage.
//  Valid/ready handshake on both sides.
// PARAMETERS
//  LANES  4   number of parallel lanes
//  DW     8   operand width per lane (fixed 8; int4 mode packs two nibbles)
//  ACCW   32  accumulator/bias width per lane, two's complement
//  CNTW   16  width of beat counter / cfg_len
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            synchronous active-low reset
//  cfg_len    in   CNTW         beats per dot product; 0 treated as 1
//  cfg_shift  in   5            requantize right-shift amount, 0..31
//  cfg_int4   in   1            1: each byte = {hi,lo} signed int4 pair
//  in_valid   in   1            operand beat valid
//  in_ready   out  1            block can accept a beat
//  in_a       in   LANES*DW     lane i operand A = in_a[i*DW+:DW], signed
//  in_b       in   LANES*DW     lane i operand B, signed
//  in_bias    in   LANES*ACCW   per-lane bias, sampled with the first beat
//  out_valid  out  1            result valid, held until accepted
//  out_ready  in   1            downstream accepts result
//  out_data   out  LANES*8      lane i int8 result = out_data[i*8+:8]
//  out_sat    out  LANES        lane i result was clipped
//  busy       out  1            state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state IDLE, all accumulators, pipeline regs, counter, out_data, out_sat,
//   out_valid = 0. Any in-flight dot product is discarded, with no partial output.
//  Beat accepted when in_valid & in_ready at a rising edge.
//  FSM:
//   IDLE  -> ACC   on first accepted beat. Latches cfg_len, cfg_shift, cfg_int4, in_bias; zeroes accumulators.
//   ACC   -> FLUSH on the beat that makes accepted count == latched len (len=1 goes IDLE->FLUSH directly).
//   FLUSH  exactly 2 cycles; pipeline drain.
//   OUT   -> IDLE  on out_valid & out_ready.
//  in_ready = 1 in IDLE/ACC, 0 in FLUSH/OUT. in_ready has no combinational path from out_ready.
//  cfg_* changes after the first beat have no effect until the next IDLE.
//  Pipeline:
//   S1: product registered the edge a beat is accepted.
//   S2: accumulate one edge later.
//   S3: bias + requant + saturate registered one edge after that.
//  Latency: last beat accepted at edge t -> out_valid=1 in the cycle after edge t+2.
//  Minimum period per dot product = len+3 cycles + output handshake.
//  int8 mode: product = a*b, signed 16-bit, sign-extended to ACCW.
//  int4 mode: product = a[3:0]*b[3:0] + a[7:4]*b[7:4], nibbles signed.
//  Accumulator wraps modulo 2^ACCW; there is no overflow flag.
//  Requant: s = acc + bias (wraps ACCW).
//   If shift > 0: r = (s + 2^(shift-1)) >>> shift (round half toward +inf).
//   If shift = 0: r = s.
//  Saturation: r > 127 -> 127; r < -128 -> -128. out_sat[i] = 1 iff clipped.
//  out_data/out_sat are stable while out_valid & !out_ready. Both are cleared to 0 when the result is accepted.
//  Bubbles (in_valid=0) in ACC stall accumulation only; the counter does not advance.
// STRUCTURE
//  Shared package mac_pkg: state enum {IDLE,ACC,FLUSH,OUT}, INT8_MAX=127, INT8_MIN=-128, default LANES/ACCW.
//  One sub-module: mac_qdot_lane, instantiated LANES times.
//   Contains: multiplier (int8/int4), accumulator, bias/round/shift/saturate.
//   Interface: en_mul, en_acc, clr, mode, shift, bias.
//  Top level holds the FSM, beat counter, cfg latches, and handshake.
// TESTING (LANES=4; values are lane 0; other lanes are random and checked against a model)
//  1 Basic: len=1, shift=0, a=3, b=-4, bias=0 -> out_data=0xF4 (-12), out_sat=0, out_valid 3 cycles after accept.
//  2 Saturate/round:
//    a=b=127, len=4 (acc=64516), shift=0 -> 127, sat=1.
//    Same inputs, shift=9 -> 126, sat=0.
//  3 Rounding sign:
//    acc=5, shift=1 -> 3.
//    acc=-5, shift=1 -> -2.
//    bias=-10, acc=0, shift=0 -> -10.
//  4 int4: cfg_int4=1, a=0x2F, b=0x3F, len=1 -> 2*3 + (-1)(-1) = 7.
//  5 Backpressure/bubbles:
//    len=8 with in_valid low on beats 3 and 5 -> same result as no bubbles.
//    out_ready low for 5 cycles -> out_data stable, in_ready=0; accept -> IDLE next cycle.
//  6 Reset mid-ACC: rst_n=0 one cycle after beat 2 of len=4 -> busy=0, out_valid=0.
//    Next dot product len=1, a=b=1 -> 1 (no stale sum).

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the quantized dot-product MAC.
// Contents: controller state encoding, int8 clip limits, default lane count and accumulator width.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int INT8_MAX  = 127;
    localparam int INT8_MIN  = -128;
    localparam int LANES_DEF = 4;
    localparam int ACCW_DEF  = 32;

endpackage

// File: rtl/mac_qdot_lane.sv
// One lane of the dot-product MAC: multiplier (int8 or packed int4 pair), wrapping accumulator,
// and the bias / rounding shift / int8 saturation output stage.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   en_mul          register the product of a and b (beat accepted)
//   en_acc          add the registered product into the accumulator
//   clr             zero the accumulator (first beat of a dot product)
//   mode            0: int8 product, 1: sum of two signed int4 nibble products
//   shift           requantize right-shift amount
//   bias            bias added to the accumulator before requantization
//   a, b            signed operands
//   ld              register the requantized result
//   drop            clear the result registers (result accepted downstream)
//   data, sat       int8 result and clip flag
module mac_qdot_lane
    import mac_pkg::*;
#(
    parameter int DW   = 8,
    parameter int ACCW = ACCW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_mul,
    input  logic            en_acc,
    input  logic            clr,
    input  logic            mode,
    input  logic [4:0]      shift,
    input  logic [ACCW-1:0] bias,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic            ld,
    input  logic            drop,
    output logic [7:0]      data,
    output logic            sat
);

    localparam logic signed [ACCW:0] CLIP_HI = (ACCW+1)'(INT8_MAX);
    localparam logic signed [ACCW:0] CLIP_LO = (ACCW+1)'(INT8_MIN);

    logic signed [15:0] a_w, b_w, a_lo, b_lo, a_hi, b_hi, prod;
    logic [ACCW-1:0]    prod_q, acc, sum;
    logic signed [ACCW:0] s_ext, rnd, r;
    logic [7:0]         data_d;
    logic               sat_d;

    // All operands widened to 16 bits so the int4 pair sum (up to 128) cannot overflow.
    always_comb begin
        a_w  = {{(16-DW){a[DW-1]}}, a};
        b_w  = {{(16-DW){b[DW-1]}}, b};
        a_lo = {{12{a[3]}}, a[3:0]};
        b_lo = {{12{b[3]}}, b[3:0]};
        a_hi = {{12{a[7]}}, a[7:4]};
        b_hi = {{12{b[7]}}, b[7:4]};
        prod = mode ? (a_lo * b_lo + a_hi * b_hi) : (a_w * b_w);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q <= '0;
            acc    <= '0;
        end else begin
            if (en_mul)
                prod_q <= {{(ACCW-16){prod[15]}}, prod};
            if (clr)
                acc <= '0;
            else if (en_acc)
                acc <= acc + prod_q;
        end
    end

    // Rounding is done one bit wider than the accumulator so adding the half-LSB cannot wrap.
    always_comb begin
        sum   = acc + bias;
        s_ext = {sum[ACCW-1], sum};
        rnd   = '0;
        if (shift != 5'd0)
            rnd = (ACCW+1)'(1) << (shift - 5'd1);
        r      = (s_ext + rnd) >>> shift;
        sat_d  = 1'b1;
        data_d = 8'h7F;
        if (r > CLIP_HI) begin
            data_d = 8'h7F;
        end else if (r < CLIP_LO) begin
            data_d = 8'h80;
        end else begin
            sat_d  = 1'b0;
            data_d = r[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
            sat  <= 1'b0;
        end else if (drop) begin
            data <= '0;
            sat  <= 1'b0;
        end else if (ld) begin
            data <= data_d;
            sat  <= sat_d;
        end
    end

endmodule

// File: rtl/mac_qdot.sv
// Multi-lane quantized dot-product MAC. Accepts cfg_len operand beats per dot product, then emits
// one requantized, saturated int8 result per lane with a valid/ready handshake.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   cfg_len, cfg_shift, cfg_int4  dot-product length (0 means 1), right shift, int4 packing
//   in_valid, in_ready            operand beat handshake
//   in_a, in_b, in_bias           per-lane operands; bias sampled with the first beat
//   out_valid, out_ready          result handshake
//   out_data, out_sat             per-lane int8 results and clip flags
//   busy                          controller not idle
//
// state | meaning
// IDLE  | waiting for the first beat of a dot product
// ACC   | accepting the remaining beats
// FLUSH | two cycles draining accumulate and requantize stages
// OUT   | result presented, waiting for out_ready
module mac_qdot
    import mac_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DW    = 8,
    parameter int ACCW  = ACCW_DEF,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CNTW-1:0]       cfg_len,
    input  logic [4:0]            cfg_shift,
    input  logic                  cfg_int4,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_a,
    input  logic [LANES*DW-1:0]   in_b,
    input  logic [LANES*ACCW-1:0] in_bias,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*8-1:0]    out_data,
    output logic [LANES-1:0]      out_sat,
    output logic                  busy
);

    state_t state, state_nx;

    logic [CNTW-1:0]       cnt, len_q, len_eff;
    logic [4:0]            shift_q;
    logic                  int4_q;
    logic [LANES*ACCW-1:0] bias_q;
    logic                  flush_cnt, acc_en_q;
    logic                  beat, first, ld_out, take_out, mode;

    assign in_ready  = (state == IDLE) || (state == ACC);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign beat      = in_valid & in_ready;
    assign first     = beat && (state == IDLE);
    assign take_out  = out_valid & out_ready;
    assign ld_out    = (state == FLUSH) && flush_cnt;
    assign len_eff   = (cfg_len == '0) ? CNTW'(1) : cfg_len;
    // The first beat's product is formed before int4_q has been latched.
    assign mode      = first ? cfg_int4 : int4_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (beat) state_nx = (len_eff == CNTW'(1)) ? FLUSH : ACC;
            ACC:     if (beat && (cnt + CNTW'(1)) == len_q) state_nx = FLUSH;
            FLUSH:   if (flush_cnt) state_nx = OUT;
            OUT:     if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            len_q     <= '0;
            shift_q   <= '0;
            int4_q    <= 1'b0;
            bias_q    <= '0;
            flush_cnt <= 1'b0;
            acc_en_q  <= 1'b0;
        end else begin
            acc_en_q  <= beat;
            flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
            if (first) begin
                cnt     <= CNTW'(1);
                len_q   <= len_eff;
                shift_q <= cfg_shift;
                int4_q  <= cfg_int4;
                bias_q  <= in_bias;
            end else if (beat) begin
                cnt <= cnt + CNTW'(1);
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_qdot_lane #(
            .DW   (DW),
            .ACCW (ACCW)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_mul (beat),
            .en_acc (acc_en_q),
            .clr    (first),
            .mode   (mode),
            .shift  (shift_q),
            .bias   (bias_q[i*ACCW +: ACCW]),
            .a      (in_a[i*DW +: DW]),
            .b      (in_b[i*DW +: DW]),
            .ld     (ld_out),
            .drop   (take_out),
            .data   (out_data[i*8 +: 8]),
            .sat    (out_sat[i])
        );
    end

endmodule

// File: tb/tb_mac_qdot.sv
module tb_mac_qdot;

    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int ACCW  = 32;
    localparam int CNTW  = 16;

    logic                  clk;
    logic                  rst_n;
    logic [CNTW-1:0]       cfg_len;
    logic [4:0]            cfg_shift;
    logic                  cfg_int4;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*DW-1:0]   in_a;
    logic [LANES*DW-1:0]   in_b;
    logic [LANES*ACCW-1:0] in_bias;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*8-1:0]    out_data;
    logic [LANES-1:0]      out_sat;
    logic                  busy;

    typedef struct packed {
        logic [LANES*8-1:0] data;
        logic [LANES-1:0]   sat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    mac_qdot #(.LANES(LANES), .DW(DW), .ACCW(ACCW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_len   (cfg_len),
        .cfg_shift (cfg_shift),
        .cfg_int4  (cfg_int4),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_bias   (in_bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int nib(input logic [3:0] n);
        return n[3] ? int'(n) - 16 : int'(n);
    endfunction

    function automatic int mul(input logic [7:0] a, input logic [7:0] b, input bit m);
        if (m)
            return nib(a[3:0]) * nib(b[3:0]) + nib(a[7:4]) * nib(b[7:4]);
        return int'($signed(a)) * int'($signed(b));
    endfunction

    function automatic logic [8:0] requant(input int acc, input int bias, input int shift);
        int         s;
        longint     r;
        logic [8:0] res;
        s = acc + bias;
        r = longint'(s);
        if (shift > 0)
            r = (r + (longint'(1) << (shift - 1))) >>> shift;
        if (r > 127)       res = {1'b1, 8'h7F};
        else if (r < -128) res = {1'b1, 8'h80};
        else               res = {1'b0, r[7:0]};
        return res;
    endfunction

    // Drives one dot product (lane 0 fixed operands, other lanes random), scrambles cfg after the
    // first beat, pushes the model result, and returns the cycle count until out_valid (-1 on timeout).
    task automatic drive_dot(input int len, input int shift, input bit int4, input int bias0,
                             input logic [7:0] a0, input logic [7:0] b0,
                             input int bub1, input int bub2, output int lat);
        int         nbeats;
        int         acc[LANES];
        int         bias[LANES];
        logic [7:0] av, bv;
        logic [8:0] q;
        exp_t       e;
        nbeats = (len == 0) ? 1 : len;
        for (int i = 0; i < LANES; i++) begin
            acc[i]  = 0;
            bias[i] = (i == 0) ? bias0 : int'($urandom_range(0, 600)) - 300;
        end
        for (int k = 1; k <= nbeats; k++) begin
            if (k == bub1 || k == bub2) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_a     = LANES*DW'($urandom);
                in_b     = LANES*DW'($urandom);
                @(posedge clk);
            end
            @(negedge clk);
            if (k == 1) begin
                cfg_len   = CNTW'(len);
                cfg_shift = 5'(shift);
                cfg_int4  = int4;
                for (int i = 0; i < LANES; i++) in_bias[i*ACCW +: ACCW] = bias[i];
            end else begin
                cfg_len   = CNTW'($urandom);
                cfg_shift = 5'($urandom);
                cfg_int4  = 1'($urandom);
                in_bias   = {LANES{$urandom}};
            end
            in_valid = 1'b1;
            for (int i = 0; i < LANES; i++) begin
                av = (i == 0) ? a0 : 8'($urandom);
                bv = (i == 0) ? b0 : 8'($urandom);
                in_a[i*DW +: DW] = av;
                in_b[i*DW +: DW] = bv;
                acc[i] += mul(av, bv, int4);
            end
            @(posedge clk);
        end
        for (int i = 0; i < LANES; i++) begin
            q = requant(acc[i], bias[i], shift);
            e.data[i*8 +: 8] = q[7:0];
            e.sat[i]         = q[8];
        end
        sb.push_back(e);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            cfg_shift = 5'($urandom);
            cfg_int4  = 1'($urandom);
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic accept_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        cfg_len = 16'd1; cfg_shift = 5'd0; cfg_int4 = 1'b0;
        in_a = '1; in_b = '1; in_bias = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        n_vec++;
        if ({out_valid, busy, in_ready, out_data, out_sat} !== {1'b0, 1'b0, 1'b1, 32'h0, 4'h0}) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b busy=%b rdy=%b data=%h sat=%b want 0 0 1 0 0",
                     out_valid, busy, in_ready, out_data, out_sat);
        end
    endtask

    task automatic test_basic();
        int lat; exp_t e;
        drive_dot(1, 0, 1'b0, 0, 8'd3, 8'hFC, 0, 0, lat);
        e = sb.pop_front();
        n_vec++;
        if (lat !== 3) begin n_err++; $display("FAIL basic_latency: got %0d want 3", lat); end
        n_vec++;
        if ({out_sat[0], out_data[7:0]} !== 9'h0F4) begin
            n_err++; $display("FAIL basic_lane0: got sat=%b data=%h want sat=0 data=f4", out_sat[0], out_data[7:0]);
        end
        n_vec++;
        if ({out_data, out_sat} !== {e.data, e.sat}) begin
            n_err++; $display("FAIL basic_lanes: got %h/%b want %h/%b", out_data, out_sat, e.data, e.sat);
        end
        accept_out();
    endtask

    task automatic test_sat_round();
        int lat; exp_t e;
        int         shifts[2] = '{0, 9};
        logic [8:0] want[2]   = '{9'h17F, 9'h07E};
        for (int t = 0; t < 2; t++) begin
            drive_dot(4, shifts[t], 1'b0, 0, 8'd127, 8'd127, 0, 0, lat);
            e = sb.pop_front();
            n_vec++;
            if ({out_sat[0], out_data[7:0]} !== want[t]) begin
                n_err++; $display("FAIL sat_round_lane0[%0d]: got sat=%b data=%h want %h", t, out_sat[0], out_data[7:0], want[t]);
            end
            n_vec++;
            if ({out_data, out_sat} !== {e.data, e.sat} || lat !== 3) begin
                n_err++; $display("FAIL sat_round_lanes[%0d]: got %h/%b lat %0d want %h/%b lat 3", t, out_data, out_sat, lat, e.data, e.sat);
            end
            accept_out();
        end
    endtask

    task automatic test_rounding_sign();
        int lat; exp_t e;
        logic [7:0] av[3]   = '{8'd5, 8'hFB, 8'd0};
        int         sh[3]   = '{1, 1, 0};
        int         bs[3]   = '{0, 0, -10};
        logic [8:0] want[3] = '{9'h003, 9'h0FE, 9'h0F6};
        for (int t = 0; t < 3; t++) begin
            drive_dot(1, sh[t], 1'b0, bs[t], av[t], 8'd1, 0, 0, lat);
            e = sb.pop_front();
            n_vec++;
            if ({out_sat[0], out_data[7:0]} !== want[t]) begin
                n_err++; $display("FAIL round_sign_lane0[%0d]: got sat=%b data=%h want %h", t, out_sat[0], out_data[7:0], want[t]);
            end
            n_vec++;
            if ({out_data, out_sat} !== {e.data, e.sat}) begin
                n_err++; $display("FAIL round_sign_lanes[%0d]: got %h/%b want %h/%b", t, out_data, out_sat, e.data, e.sat);
            end
            accept_out();
        end
    endtask

    task automatic test_int4();
        int lat; exp_t e;
        drive_dot(1, 0, 1'b1, 0, 8'h2F, 8'h3F, 0, 0, lat);
        e = sb.pop_front();
        n_vec++;
        if ({out_sat[0], out_data[7:0]} !== 9'h007) begin
            n_err++; $display("FAIL int4_lane0: got sat=%b data=%h want sat=0 data=07", out_sat[0], out_data[7:0]);
        end
        n_vec++;
        if ({out_data, out_sat} !== {e.data, e.sat}) begin
            n_err++; $display("FAIL int4_lanes: got %h/%b want %h/%b", out_data, out_sat, e.data, e.sat);
        end
        accept_out();
        drive_dot(3, 2, 1'b1, 5, 8'h9C, 8'h7A, 0, 0, lat);
        e = sb.pop_front();
        n_vec++;
        if ({out_data, out_sat} !== {e.data, e.sat}) begin
            n_err++; $display("FAIL int4_multi_lanes: got %h/%b want %h/%b", out_data, out_sat, e.data, e.sat);
        end
        accept_out();
    endtask

    task automatic test_bubbles();
        int lat; exp_t e;
        drive_dot(8, 0, 1'b0, 0, 8'd3, 8'd5, 3, 5, lat);
        e = sb.pop_front();
        n_vec++;
        if ({out_sat[0], out_data[7:0]} !== 9'h078) begin
            n_err++; $display("FAIL bubbles_lane0: got sat=%b data=%h want sat=0 data=78", out_sat[0], out_data[7:0]);
        end
        n_vec++;
        if ({out_data, out_sat} !== {e.data, e.sat} || lat !== 3) begin
            n_err++; $display("FAIL bubbles_lanes: got %h/%b lat %0d want %h/%b lat 3", out_data, out_sat, lat, e.data, e.sat);
        end
        accept_out();
    endtask

    task automatic test_backpressure();
        int lat; exp_t e; logic [31:0] hold_d; logic [3:0] hold_s; bit ok;
        drive_dot(2, 0, 1'b0, 0, 8'd10, 8'hF9, 0, 0, lat);
        e = sb.pop_front();
        hold_d = out_data;
        hold_s = out_sat;
        ok = (lat == 3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_data !== hold_d || out_sat !== hold_s || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
        end
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL bp_stable: got data=%h sat=%b rdy=%b valid=%b want held %h/%b rdy=0 valid=1",
                              out_data, out_sat, in_ready, out_valid, hold_d, hold_s);
        end
        n_vec++;
        if ({out_sat[0], out_data[7:0]} !== 9'h180 || {out_data, out_sat} !== {e.data, e.sat}) begin
            n_err++; $display("FAIL bp_result: got %h/%b want %h/%b (lane0 80 sat)", out_data, out_sat, e.data, e.sat);
        end
        accept_out();
        n_vec++;
        if ({busy, out_valid, in_ready, out_data, out_sat} !== {1'b0, 1'b0, 1'b1, 32'h0, 4'h0}) begin
            n_err++; $display("FAIL bp_after_accept: got busy=%b valid=%b rdy=%b data=%h sat=%b want 0 0 1 0 0",
                              busy, out_valid, in_ready, out_data, out_sat);
        end
    endtask

    task automatic test_reset_mid();
        int lat; exp_t e; bit seen;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cfg_len = 16'd4; cfg_shift = 5'd0; cfg_int4 = 1'b0; in_bias = '0;
            in_valid = 1'b1; in_a = 32'h7F7F7F7F; in_b = 32'h7F7F7F7F;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_state: got busy=%b valid=%b want 0 0", busy, out_valid);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin n_err++; $display("FAIL rst_mid_no_output: got out_valid=1 want 0"); end
        drive_dot(1, 0, 1'b0, 0, 8'd1, 8'd1, 0, 0, lat);
        e = sb.pop_front();
        n_vec++;
        if ({out_sat[0], out_data[7:0]} !== 9'h001 || {out_data, out_sat} !== {e.data, e.sat}) begin
            n_err++; $display("FAIL rst_mid_next: got %h/%b want %h/%b (lane0 01)", out_data, out_sat, e.data, e.sat);
        end
        accept_out();
    endtask

    task automatic test_len_zero();
        int lat; exp_t e;
        drive_dot(0, 0, 1'b0, 0, 8'd2, 8'd3, 0, 0, lat);
        e = sb.pop_front();
        n_vec++;
        if (lat !== 3 || {out_sat[0], out_data[7:0]} !== 9'h006) begin
            n_err++; $display("FAIL len_zero: got lat %0d sat=%b data=%h want lat 3 sat=0 data=06", lat, out_sat[0], out_data[7:0]);
        end
        n_vec++;
        if ({out_data, out_sat} !== {e.data, e.sat}) begin
            n_err++; $display("FAIL len_zero_lanes: got %h/%b want %h/%b", out_data, out_sat, e.data, e.sat);
        end
        accept_out();
    endtask

    task automatic test_back_to_back();
        int lat; exp_t e;
        for (int t = 0; t < 4; t++) begin
            drive_dot(int'($urandom_range(1, 6)), int'($urandom_range(0, 12)), 1'($urandom),
                      int'($urandom_range(0, 2000)) - 1000, 8'($urandom), 8'($urandom), 0, 0, lat);
            e = sb.pop_front();
            n_vec++;
            if ({out_data, out_sat} !== {e.data, e.sat} || lat !== 3) begin
                n_err++; $display("FAIL b2b[%0d]: got %h/%b lat %0d want %h/%b lat 3", t, out_data, out_sat, lat, e.data, e.sat);
            end
            accept_out();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat_round();
        test_rounding_sign();
        test_int4();
        test_bubbles();
        test_backpressure();
        test_reset_mid();
        test_len_zero();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
